framebuffer_writer: RTL and testbench

Pixel sink for the 160x120 line-drawing path: accepts (x, y, colour) plot requests from the Bresenham line generator through a valid/ready handshake, buffers them, converts coordinates to a linear framebuffer address and issues single-cycle writes to the on-chip video memory. It also performs a full-screen clear on request, and drops and counts off-screen plots. It sits between the line engine and the VGA adapter's dual-port framebuffer write port.

---
 rtl/fb_pkg.sv | 19 +
 rtl/framebuffer_writer_plot_fifo.sv | 59 +++++
 rtl/framebuffer_writer.sv | 123 ++++++++++++
 tb/tb_framebuffer_writer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared constants, types and the linear address mapping for the 160x120
// framebuffer writer.
package fb_pkg;
    localparam int H_RES    = 160;
    localparam int V_RES    = 120;
    localparam int COLOUR_W = 3;
    localparam int ADDR_W   = 15;
    localparam int PIXELS   = H_RES * V_RES;

    typedef logic [COLOUR_W-1:0] colour_t;
    typedef enum logic [1:0] {IDLE, RUN, CLEAR} state_t;

    // 160 = 128 + 32, so y*160 collapses to two shifts and an add.
    function automatic logic [ADDR_W-1:0] fb_addr(input logic [6:0] y, input logic [7:0] x);
        logic [ADDR_W-1:0] yw;
        yw = ADDR_W'(y);
        return (yw << 7) + (yw << 5) + ADDR_W'(x);
    endfunction
endpackage

// File: rtl/framebuffer_writer_plot_fifo.sv
// Small synchronous FIFO holding pending plot requests; full/empty are
// registered so the upstream ready never depends combinationally on valid.
module plot_fifo
    import fb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 18
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count_n;
    logic          do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_comb begin
        count_n = count;
        if (do_push && !do_pop)
            count_n = count + CW'(1);
        else if (!do_push && do_pop)
            count_n = count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            count <= count_n;
            full  <= (count_n == CW'(DEPTH));
            empty <= (count_n == '0);
        end
    end

    // Storage needs no reset: pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end
endmodule

// File: rtl/framebuffer_writer.sv
// Plot sink for the line engine: buffers (x, y, colour) requests, maps them to
// linear framebuffer writes, drops off-screen plots and sweeps the screen on clear.
module framebuffer_writer #(
    parameter int H_RES      = fb_pkg::H_RES,
    parameter int V_RES      = fb_pkg::V_RES,
    parameter int COLOUR_W   = fb_pkg::COLOUR_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      plot_valid,
    output logic                      plot_ready,
    input  logic [7:0]                plot_x,
    input  logic [6:0]                plot_y,
    input  logic [COLOUR_W-1:0]       plot_colour,
    input  logic                      clear_req,
    input  logic [COLOUR_W-1:0]       clear_colour,
    output logic                      busy,
    output logic                      mem_we,
    output logic [fb_pkg::ADDR_W-1:0] mem_addr,
    output logic [COLOUR_W-1:0]       mem_wdata,
    output logic [7:0]                drop_count
);
    import fb_pkg::*;

    localparam int EW = 15 + COLOUR_W;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

    state_t              state, state_n;
    logic                push, pop, full, empty;
    logic [CW-1:0]       fifo_count;
    logic [EW-1:0]       rd_entry;
    logic                nonempty_n, s1_vld_n, we_n, onscreen;

    // Address stage: either a popped plot or one sweep address.
    logic                s1_vld, s1_clr;
    logic [7:0]          s1_x;
    logic [6:0]          s1_y;
    logic [COLOUR_W-1:0] s1_col;
    logic [ADDR_W-1:0]   s1_caddr;

    logic [ADDR_W-1:0]   clr_cnt;
    logic [COLOUR_W-1:0] clr_col;

    plot_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .pop    (pop),
        .wdata  ({plot_x, plot_y, plot_colour}),
        .rdata  (rd_entry),
        .full   (full),
        .empty  (empty),
        .count  (fifo_count)
    );

    assign plot_ready = !full;

    always_comb begin
        push       = plot_valid && !full;
        // A clear request wins over a pop so a plot sitting in the buffer is
        // drawn after the sweep rather than racing it.
        pop        = !empty && (state != CLEAR) && !clear_req;
        nonempty_n = push || (fifo_count > CW'(1)) || (!empty && !pop);
        state_n    = state;
        case (state)
            IDLE, RUN: begin
                if (clear_req) state_n = CLEAR;
                else           state_n = nonempty_n ? RUN : IDLE;
            end
            CLEAR: if (clr_cnt == LAST_ADDR) state_n = nonempty_n ? RUN : IDLE;
            default: state_n = IDLE;
        endcase
        s1_vld_n = pop || (state == CLEAR);
        onscreen = (s1_x < 8'(H_RES)) && (s1_y < 7'(V_RES));
        we_n     = s1_vld && (s1_clr || onscreen);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            s1_vld     <= 1'b0;
            s1_clr     <= 1'b0;
            s1_x       <= '0;
            s1_y       <= '0;
            s1_col     <= '0;
            s1_caddr   <= '0;
            clr_cnt    <= '0;
            clr_col    <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            drop_count <= '0;
            busy       <= 1'b0;
        end else begin
            state <= state_n;
            if (state != CLEAR && clear_req) begin
                clr_col <= clear_colour;
                clr_cnt <= '0;
            end else if (state == CLEAR) begin
                clr_cnt <= clr_cnt + ADDR_W'(1);
            end

            s1_vld   <= s1_vld_n;
            s1_clr   <= (state == CLEAR);
            s1_caddr <= clr_cnt;
            if (pop) {s1_x, s1_y, s1_col} <= rd_entry;

            mem_we <= we_n;
            if (we_n) begin
                mem_addr  <= s1_clr ? s1_caddr : fb_addr(s1_y, s1_x);
                mem_wdata <= s1_clr ? clr_col  : s1_col;
            end
            if (s1_vld && !s1_clr && !onscreen && drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;

            // Busy covers the output write register too, so it falls only
            // after the final write has been presented.
            busy <= (state_n != IDLE) || nonempty_n || s1_vld_n || we_n;
        end
    end
endmodule

// File: tb/tb_framebuffer_writer.sv
// Directed bench for framebuffer_writer: plot latency, bursts, off-screen drops,
// clear sweeps, full-buffer stall and reset during a sweep.
module tb_framebuffer_writer;
    logic        clk = 1'b0;
    logic        resetn;
    logic        plot_valid;
    logic        plot_ready;
    logic [7:0]  plot_x;
    logic [6:0]  plot_y;
    logic [2:0]  plot_colour;
    logic        clear_req;
    logic [2:0]  clear_colour;
    logic        busy;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [2:0]  mem_wdata;
    logic [7:0]  drop_count;

    typedef struct {
        logic [14:0] addr;
        logic [2:0]  data;
        int          cyc;
    } wr_t;

    wr_t wq[$];
    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;

    framebuffer_writer dut (
        .clk          (clk),
        .resetn       (resetn),
        .plot_valid   (plot_valid),
        .plot_ready   (plot_ready),
        .plot_x       (plot_x),
        .plot_y       (plot_y),
        .plot_colour  (plot_colour),
        .clear_req    (clear_req),
        .clear_colour (clear_colour),
        .busy         (busy),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (mem_we === 1'b1) wq.push_back('{mem_addr, mem_wdata, cyc});

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) tick();
        checks++; if (plot_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", plot_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", mem_we); end
        checks++; if (mem_addr !== 15'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", mem_addr); end
        checks++; if (mem_wdata !== 3'd0) begin errors++; $display("FAIL reset_wdata: got %0d want 0", mem_wdata); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
        resetn = 1'b1;
        tick();
        wq.delete();
    endtask

    task automatic test_single_plot();
        wq.delete();
        plot_x = 8'd5; plot_y = 7'd3; plot_colour = 3'b101; plot_valid = 1'b1;
        tick();
        plot_valid = 1'b0;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL single_we_k: got %b want 0", mem_we); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
        tick();
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL single_we_k1: got %b want 0", mem_we); end
        tick();
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 15'd485 || mem_wdata !== 3'b101) begin
            errors++; $display("FAIL single_write: got we=%b addr=%0d data=%0d want we=1 addr=485 data=5", mem_we, mem_addr, mem_wdata);
        end
        tick();
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL single_pulse: got we=%b want 0", mem_we); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got busy=%b want 0", busy); end
        checks++; if (wq.size() != 1) begin errors++; $display("FAIL single_count: got %0d writes want 1", wq.size()); end
    endtask

    task automatic test_burst();
        logic [7:0]  bx [6] = '{0, 159, 0, 159, 10, 100};
        logic [6:0]  by [6] = '{0, 0, 119, 119, 20, 50};
        logic [14:0] ea [6] = '{0, 159, 19040, 19199, 3210, 8100};
        logic [2:0]  ec [6] = '{1, 2, 3, 4, 5, 6};
        wq.delete();
        plot_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            plot_x = bx[i]; plot_y = by[i]; plot_colour = ec[i];
            checks++; if (plot_ready !== 1'b1) begin errors++; $display("FAIL burst_ready[%0d]: got %b want 1", i, plot_ready); end
            tick();
        end
        plot_valid = 1'b0;
        tick(); tick();
        checks++;
        if (mem_we !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL burst_last: got we=%b busy=%b want 1 1", mem_we, busy);
        end
        tick();
        checks++;
        if (mem_we !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL burst_end: got we=%b busy=%b want 0 0", mem_we, busy);
        end
        checks++; if (wq.size() != 6) begin errors++; $display("FAIL burst_count: got %0d want 6", wq.size()); end
        for (int i = 0; i < 6 && i < wq.size(); i++) begin
            checks++;
            if (wq[i].addr !== ea[i] || wq[i].data !== ec[i] || wq[i].cyc != wq[0].cyc + i) begin
                errors++;
                $display("FAIL burst_write[%0d]: got addr=%0d data=%0d cyc+%0d want addr=%0d data=%0d cyc+%0d",
                         i, wq[i].addr, wq[i].data, wq[i].cyc - wq[0].cyc, ea[i], ec[i], i);
            end
        end
    endtask

    task automatic test_offscreen();
        wq.delete();
        plot_valid = 1'b1; plot_colour = 3'd1;
        plot_x = 8'd160; plot_y = 7'd0;   tick();
        plot_x = 8'd0;   plot_y = 7'd120; tick();
        plot_x = 8'd255; plot_y = 7'd127; tick();
        plot_valid = 1'b0;
        repeat (4) tick();
        checks++; if (wq.size() != 0) begin errors++; $display("FAIL off_writes: got %0d want 0", wq.size()); end
        checks++; if (drop_count !== 8'd3) begin errors++; $display("FAIL off_drop: got %0d want 3", drop_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL off_busy: got %b want 0", busy); end
    endtask

    task automatic test_drop_saturate();
        plot_valid = 1'b1; plot_x = 8'd200; plot_y = 7'd10;
        repeat (200) tick();
        plot_valid = 1'b0;
        repeat (4) tick();
        checks++; if (drop_count !== 8'd203) begin errors++; $display("FAIL drop_203: got %0d want 203", drop_count); end
        plot_valid = 1'b1;
        repeat (100) tick();
        plot_valid = 1'b0;
        repeat (4) tick();
        checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL drop_sat: got %0d want 255", drop_count); end
        checks++; if (wq.size() != 0) begin errors++; $display("FAIL drop_writes: got %0d want 0", wq.size()); end
    endtask

    task automatic test_clear();
        int bad;
        wq.delete();
        clear_req = 1'b1; clear_colour = 3'b010;
        plot_valid = 1'b1; plot_x = 8'd1; plot_y = 7'd1; plot_colour = 3'd7;
        tick();
        clear_req = 1'b0; plot_x = 8'd2; plot_y = 7'd0; plot_colour = 3'd6;
        tick();
        plot_valid = 1'b0;
        checks++; if (mem_we !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL clear_k1: got we=%b busy=%b want 0 1", mem_we, busy); end
        tick();
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 15'd0 || mem_wdata !== 3'b010) begin
            errors++; $display("FAIL clear_first: got we=%b addr=%0d data=%0d want 1 0 2", mem_we, mem_addr, mem_wdata);
        end
        repeat (5000) tick();
        clear_req = 1'b1; clear_colour = 3'b111;
        tick();
        clear_req = 1'b0;
        for (int n = 0; n < 20000 && wq.size() < 19202; n++) tick();
        checks++;
        if (wq.size() < 19202) begin
            errors++; $display("FAIL clear_timeout: got %0d writes want 19202", wq.size());
        end else begin
            bad = -1;
            for (int i = 0; i < 19200; i++)
                if (wq[i].addr !== 15'(i) || wq[i].data !== 3'b010 || wq[i].cyc != wq[0].cyc + i) begin bad = i; break; end
            checks++; if (bad != -1) begin errors++; $display("FAIL clear_sweep: bad entry %0d addr=%0d data=%0d want addr=%0d data=2", bad, wq[bad].addr, wq[bad].data, bad); end
            checks++; if (wq[19200].addr !== 15'd161 || wq[19200].data !== 3'd7) begin errors++; $display("FAIL clear_plot1: got %0d/%0d want 161/7", wq[19200].addr, wq[19200].data); end
            checks++; if (wq[19201].addr !== 15'd2 || wq[19201].data !== 3'd6) begin errors++; $display("FAIL clear_plot2: got %0d/%0d want 2/6", wq[19201].addr, wq[19201].data); end
        end
        repeat (5) tick();
        checks++; if (wq.size() != 19202) begin errors++; $display("FAIL clear_total: got %0d want 19202", wq.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_busy: got %b want 0", busy); end
    endtask

    task automatic test_full_stall();
        logic [7:0]  fx [5] = '{3, 159, 0, 80, 7};
        logic [6:0]  fy [5] = '{4, 119, 0, 60, 7};
        logic [14:0] fa [5] = '{643, 19199, 0, 9680, 1127};
        logic [2:0]  fc [5] = '{1, 2, 3, 4, 5};
        int stall = 0;
        int bad;
        wq.delete();
        clear_req = 1'b1; clear_colour = 3'b001;
        tick();
        clear_req = 1'b0;
        plot_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            plot_x = fx[i]; plot_y = fy[i]; plot_colour = fc[i];
            checks++; if (plot_ready !== 1'b1) begin errors++; $display("FAIL stall_ready[%0d]: got %b want 1", i, plot_ready); end
            tick();
        end
        plot_x = fx[4]; plot_y = fy[4]; plot_colour = fc[4];
        checks++; if (plot_ready !== 1'b0) begin errors++; $display("FAIL stall_full: got ready=%b want 0", plot_ready); end
        while (plot_ready !== 1'b1 && stall < 20000) begin tick(); stall++; end
        tick();
        plot_valid = 1'b0;
        checks++; if (stall != 19197) begin errors++; $display("FAIL stall_len: got %0d cycles want 19197", stall); end
        for (int n = 0; n < 100 && wq.size() < 19205; n++) tick();
        checks++;
        if (wq.size() != 19205) begin
            errors++; $display("FAIL stall_count: got %0d writes want 19205", wq.size());
        end else begin
            bad = -1;
            for (int i = 0; i < 19200; i++)
                if (wq[i].addr !== 15'(i) || wq[i].data !== 3'b001) begin bad = i; break; end
            checks++; if (bad != -1) begin errors++; $display("FAIL stall_sweep: bad entry %0d addr=%0d data=%0d", bad, wq[bad].addr, wq[bad].data); end
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (wq[19200+i].addr !== fa[i] || wq[19200+i].data !== fc[i]) begin
                    errors++; $display("FAIL stall_plot[%0d]: got %0d/%0d want %0d/%0d", i, wq[19200+i].addr, wq[19200+i].data, fa[i], fc[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        int n = 0;
        wq.delete();
        clear_req = 1'b1; clear_colour = 3'b011;
        plot_valid = 1'b1; plot_x = 8'd9; plot_y = 7'd9; plot_colour = 3'd2;
        tick();
        clear_req = 1'b0; plot_x = 8'd10;
        tick();
        plot_valid = 1'b0;
        while (!(mem_we === 1'b1 && mem_addr === 15'd1000) && n < 2000) begin tick(); n++; end
        checks++; if (n >= 2000) begin errors++; $display("FAIL rst_wait: sweep address 1000 not seen, got addr=%0d", mem_addr); end
        resetn = 1'b0;
        tick();
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", mem_we); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL rst_drop: got %0d want 0", drop_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (plot_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", plot_ready); end
        checks++; if (mem_addr !== 15'd0) begin errors++; $display("FAIL rst_addr: got %0d want 0", mem_addr); end
        resetn = 1'b1;
        wq.delete();
        repeat (40) tick();
        checks++; if (wq.size() != 0) begin errors++; $display("FAIL rst_nowrite: got %0d writes want 0", wq.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle: got busy=%b want 0", busy); end
    endtask

    initial begin
        resetn = 1'b0; plot_valid = 1'b0; plot_x = '0; plot_y = '0; plot_colour = '0;
        clear_req = 1'b0; clear_colour = '0;
        test_reset();
        test_single_plot();
        test_burst();
        test_offscreen();
        test_drop_saturate();
        test_clear();
        test_full_stall();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
